move_scheduler: RTL
===================

# move_scheduler

Sequences buffered coordinated moves from the SPI command decoder into the DDA step timer. It owns a ring buffer of move descriptors (direction, duration, increment, incrementincrement), accepts writes through a valid/ready handshake and presents one descriptor at a time to the DDA. It advances only on the DDA's completion pulse and drives the BUFFER_DTR and MOVE_DONE status pins. It sits between the word-level command state machine and `dda_timer`, replacing the toggle-based stepready/stepfinished latching.

## Interface
- `MOVE_BUFFER_BITS`, default 2: buffer depth is 2^MOVE_BUFFER_BITS entries (default 4).
- `W`, default 64: width of the duration, increment and incrementincrement fields.

- `CLK`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `wr_valid`  in  1  decoder has a complete move descriptor.
- `wr_ready`  out  1  buffer can accept; equals count < DEPTH.
- `wr_dir`  in  1  direction bit of the move.
- `wr_duration`  in  W  move duration in DDA ticks.
- `wr_increment`  in  W  signed initial increment.
- `wr_incrementincrement`  in  W  signed acceleration term.
- `dda_done`  in  1  one-cycle pulse from the DDA when the current move completes.
- `halt`  in  1  level-sensitive stop request (HALT pin).
- `move_start`  out  1  one-cycle pulse; the DDA latches the descriptor outputs.
- `move_active`  out  1  a descriptor is loaded and running.
- `move_dir`, `move_duration`, `move_increment`, `move_incrementincrement`  out  1/W/W/W  registered descriptor of the active move.
- `move_done`  out  1  one-cycle pulse when the last queued move finishes.
- `move_abort`  out  1  one-cycle pulse when a halt flush discards moves (flush builds only).
- `buffer_dtr`  out  1  host flow control; high when at least one slot is free.
- `level`  out  MOVE_BUFFER_BITS+1  occupied entries, including the active move.

## Operation
- The buffer is a ring with wr_ptr and rd_ptr of MOVE_BUFFER_BITS bits each. Pointers wrap modulo DEPTH.
- The count is held in a separate MOVE_BUFFER_BITS+1-bit counter, so a full buffer and an empty buffer are distinct states.
- Write: when wr_valid and wr_ready are both high, the four fields are stored at wr_ptr, then wr_ptr and count increment.
- A write while full (wr_ready low) is ignored and must not corrupt state.
- FSM states:
  - IDLE: if count > 0 and halt is low, go to LOAD.
  - LOAD (one cycle): register the entry at rd_ptr onto the move_* outputs, pulse move_start, go to RUN.
  - RUN: move_active is high. On dda_done, increment rd_ptr and decrement count.
    - If the remaining count > 0 and halt is low, go to LOAD.
    - Otherwise go to IDLE, pulsing move_done if the remaining count = 0.
- The active entry stays counted in `level` until its dda_done.
- A write and a pop in the same cycle leave count unchanged; both pointers advance.
- dda_done received outside RUN is ignored.
- halt without flush: no new LOAD occurs. A move already running continues until its dda_done; the DDA handles halting of the running move itself.
- move_* outputs hold their last values while in IDLE.

## Timing
- Reset values:
  - count, wr_ptr, rd_ptr: 0; state: IDLE.
  - move_start, move_active, move_done, move_abort: 0.
  - move_* data outputs: 0.
  - wr_ready and buffer_dtr: 1; level: 0.
- Latency from an accepted write into an empty, idle, unhalted buffer: move_start pulses 2 cycles after the write edge (one cycle for the count update, one cycle in LOAD).
- Back-to-back moves: dda_done in cycle N gives move_start in cycle N+2.
- wr_ready, buffer_dtr and level are combinational from the count. They reflect a write or pop in the cycle after that edge.
- When resetn deasserts mid-move, all pointers and outputs clear immediately. The DDA must be reset by the same resetn.

## Configuration
- `MOVE_SCHEDULER_FLUSH_EN` defined:
  - When halt rises in any state, on the next edge count, wr_ptr and rd_ptr clear and the FSM goes to IDLE.
  - move_active drops and move_abort pulses for one cycle if count was > 0; move_done does not pulse.
  - Writes that coincide with the flush cycle are dropped.
- `MOVE_SCHEDULER_FLUSH_EN` undefined: halt only blocks LOAD, the queue is preserved, and move_abort is tied to 0.

## Test plan
- Reset: assert resetn low mid-RUN with level=3 -> all outputs reach their reset values asynchronously; wr_ready=1, level=0.
- Single move: write dur=100 into an empty buffer at cycle 0 -> move_start at cycle 2 with move_duration=100. dda_done at cycle 50 -> move_done pulses at cycle 51 and level=0.
- Fill and wrap (depth 4): write 5 moves back to back -> the 5th is stalled with wr_ready=0 and buffer_dtr=0. After the first dda_done the 5th is accepted at slot 0. The moves play out in order 1..5 with their direction bits intact.
- Simultaneous events: write in the same cycle as dda_done with level=2 -> level stays 2 and the next move_start comes 2 cycles after dda_done.
- Halt without flush: hold halt high during RUN with 2 moves queued -> the current move completes, no move_start occurs and level=2. Release halt -> move_start 2 cycles later.
- Halt with flush (MOVE_SCHEDULER_FLUSH_EN): raise halt with level=3 -> next cycle level=0, move_abort=1 and move_done=0. A subsequent write produces a normal start.

Source files
------------

// File: rtl/move_scheduler.sv
// move_scheduler: ring buffer of DDA move descriptors, presenting one move at a time to dda_timer.
// Build option MOVE_SCHEDULER_FLUSH_EN: a rising HALT discards the whole queue and pulses move_abort.
module move_scheduler #(
    parameter int MOVE_BUFFER_BITS = 2,
    parameter int W                = 64
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_dir,
    input  logic [W-1:0]              wr_duration,
    input  logic [W-1:0]              wr_increment,
    input  logic [W-1:0]              wr_incrementincrement,
    input  logic                      dda_done,
    input  logic                      halt,
    output logic                      move_start,
    output logic                      move_active,
    output logic                      move_dir,
    output logic [W-1:0]              move_duration,
    output logic [W-1:0]              move_increment,
    output logic [W-1:0]              move_incrementincrement,
    output logic                      move_done,
    output logic                      move_abort,
    output logic                      buffer_dtr,
    output logic [MOVE_BUFFER_BITS:0] level
);
    localparam int DEPTH = 1 << MOVE_BUFFER_BITS;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                      state, state_d;
    logic [MOVE_BUFFER_BITS-1:0] wr_ptr, rd_ptr;
    logic [MOVE_BUFFER_BITS:0]   count, remaining;
    logic                        push, pop, flush;
    logic                        start_d, done_d, abort_d;

    logic         dir_mem    [DEPTH];
    logic [W-1:0] dur_mem    [DEPTH];
    logic [W-1:0] inc_mem    [DEPTH];
    logic [W-1:0] incinc_mem [DEPTH];

    // count never exceeds DEPTH, so its MSB alone marks a full buffer
    assign wr_ready   = ~count[MOVE_BUFFER_BITS];
    assign buffer_dtr = wr_ready;
    assign level      = count;

`ifdef MOVE_SCHEDULER_FLUSH_EN
    logic halt_q;
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) halt_q <= 1'b0;
        else         halt_q <= halt;
    end
    assign flush = halt & ~halt_q;
`else
    assign flush = 1'b0;
`endif

    assign push      = wr_valid & wr_ready & ~flush;
    assign remaining = count - 1'b1;

    always_ff @(posedge CLK) begin
        if (push) begin
            dir_mem[wr_ptr]    <= wr_dir;
            dur_mem[wr_ptr]    <= wr_duration;
            inc_mem[wr_ptr]    <= wr_increment;
            incinc_mem[wr_ptr] <= wr_incrementincrement;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (flush) begin
            state_d = IDLE;
            abort_d = (count != '0);
        end else begin
            case (state)
                IDLE: if (count != '0 && !halt) state_d = LOAD;
                LOAD: begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
                RUN: if (dda_done) begin
                    pop = 1'b1;
                    if (remaining != '0 && !halt) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = (remaining == '0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state                   <= IDLE;
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            count                   <= '0;
            move_start              <= 1'b0;
            move_active             <= 1'b0;
            move_done               <= 1'b0;
            move_abort              <= 1'b0;
            move_dir                <= 1'b0;
            move_duration           <= '0;
            move_increment          <= '0;
            move_incrementincrement <= '0;
        end else begin
            state       <= state_d;
            move_start  <= start_d;
            move_active <= (state_d == RUN);
            move_done   <= done_d;
            move_abort  <= abort_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            // descriptor is latched on the same edge that raises move_start
            if (start_d) begin
                move_dir                <= dir_mem[rd_ptr];
                move_duration           <= dur_mem[rd_ptr];
                move_increment          <= inc_mem[rd_ptr];
                move_incrementincrement <= incinc_mem[rd_ptr];
            end
        end
    end
endmodule
